serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial N-bit adder sequencer around a 1-bit full-adder cell (S = a^b^c, Cout = maj(a,b,c)).
//  Loads two operands, presents one bit pair per clock LSB-first with a registered carry,
//  and shifts each sum bit into a result register. Reports sum and carry-out with a done pulse.
//  Sits between operand source (regs/switches) and result display/consumer.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (legal 2..32)
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only in IDLE
//  a_in    in   WIDTH  operand A, captured on accepted start
//  b_in    in   WIDTH  operand B, captured on accepted start
//  cin     in   1      initial carry, captured on accepted start
//  busy    out  1      high while in SHIFT
//  done    out  1      one-cycle pulse: sum/cout valid
//  sum     out  WIDTH  result, held until next accepted start
//  cout    out  1      final carry, held with sum
// BEHAVIOUR
//  - Reset: async assert on rst_n low -> state IDLE; busy=0, done=0, sum=0, cout=0, cnt=0, carry_q=0.
//    Release is synchronous-safe; first action no earlier than first rising edge after rst_n high.
//  - States: IDLE -> SHIFT on start=1; SHIFT -> DONE after WIDTH shift edges; DONE -> IDLE unconditionally.
//  - IDLE: on edge with start=1: a_sh<=a_in, b_sh<=b_in, carry_q<=cin, cnt<=0, sum<=0, cout<=0, busy<=1.
//  - SHIFT, each edge: FA inputs a_sh[0], b_sh[0], carry_q; a_sh,b_sh shift right (MSB fill 0);
//    sum shifts right with FA.S entering at bit WIDTH-1; carry_q<=FA.Cout; cnt<=cnt+1.
//    On the edge where cnt==WIDTH-1: busy<=0, cout<=FA.Cout, state<=DONE.
//  - DONE: done=1 for exactly one cycle; sum/cout stable. Then IDLE.
//  - Latency: start edge to done high = WIDTH+1 edges; back-to-back start accepted in cycle after done.
//  - Arithmetic: {cout,sum} = a_in + b_in + cin, modulo 2^(WIDTH+1); never saturates.
//  - start while busy or in DONE: ignored, no queuing; operands changing during SHIFT have no effect.
//  - sum/cout read during SHIFT are partial and undefined for the consumer; qualify with done.
//  - cnt width = clog2(WIDTH)+1; no wrap beyond WIDTH-1 ever occurs.
//  - Reset mid-SHIFT: operation aborted, no done pulse, outputs cleared as above.
// CONFIGURATION
//  SERIAL_ADD_OVF_EN defined: extra output port `ovf` (out, 1) = signed two's-complement overflow,
//   i.e. carry into MSB XOR carry out of MSB, latched on the final SHIFT edge, held with sum,
//   cleared by reset and on accepted start.
//  Undefined: port `ovf` absent; no MSB-carry capture logic.
// TESTING
//  1 WIDTH=8: rst_n=0 mid-sim -> busy=0,done=0,sum=0,cout=0 immediately (no clock edge).
//  2 a=8'h05,b=8'h03,cin=0,start 1 cycle -> busy 8 cycles, done at edge 9, sum=8'h08,cout=0.
//  3 a=8'hFF,b=8'h01,cin=1 -> sum=8'h01,cout=1; OVF_EN: ovf=0.
//  4 a=8'h7F,b=8'h01,cin=0 -> sum=8'h80,cout=0; OVF_EN: ovf=1.
//  5 start held high + a_in changed during SHIFT -> result reflects captured operands only;
//    next op starts cycle after done.
//  6 rst_n pulsed low at 4th SHIFT cycle -> no done pulse; new start gives correct result.
//  Bench compares {cout,sum} vs a+b+cin for exhaustive WIDTH=4 sweep (512 cases).

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bus for the bit-serial adder sequencer.
// master: operand source / result consumer; slave: serial_adder_ctrl.
// Optional macro SERIAL_ADD_OVF_EN adds the signed-overflow flag `ovf`.
interface serial_adder_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;

   modport master (
      output start, a_in, b_in, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, a_in, b_in, cin,
      output busy, done, sum, cout, ovf
   );
`else
   modport master (
      output start, a_in, b_in, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a_in, b_in, cin,
      output busy, done, sum, cout
   );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer around a single full-adder cell.
// Operands are captured on an accepted start, added LSB-first one bit per
// clock with a registered carry, and the sum is shifted in from the MSB end.
// done pulses for one cycle when {cout,sum} = a_in + b_in + cin is valid.
// Optional macro SERIAL_ADD_OVF_EN adds bus.ovf (signed two's-complement
// overflow: carry into MSB XOR carry out of MSB).
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   serial_adder_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             cout_q;
   logic [CNT_W-1:0] cnt;
   logic             fa_s;
   logic             fa_c;
   logic             last;
   logic             busy;
   logic             done;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_q;
`endif

   // Full-adder cell on the current LSB pair plus registered carry.
   always_comb begin
      fa_s = a_sh[0] ^ b_sh[0] ^ carry_q;
      fa_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry_q) | (b_sh[0] & carry_q);
      last = (cnt == LAST);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and status outputs.
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, serial shift and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt     <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh    <= bus.a_in;
                  b_sh    <= bus.b_in;
                  carry_q <= bus.cin;
                  sum_q   <= '0;
                  cout_q  <= 1'b0;
                  cnt     <= '0;
`ifdef SERIAL_ADD_OVF_EN
                  ovf_q   <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
               b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
               sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
               carry_q <= fa_c;
               cnt     <= cnt + CNT_W'(1);
               if (last) begin
                  cout_q <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                  // carry_q here is the carry into the MSB cell
                  ovf_q  <= carry_q ^ fa_c;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vector table, multi-cycle
// corner sequences, random WIDTH=8 operations and an exhaustive WIDTH=4 sweep.
module tb_serial_adder_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
   serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

   serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   serial_adder_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [7:0] s;
      logic       co;
      logic       ov;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer addition, overflow from operand/result signs.
   function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b, input logic c);
      int unsigned r;
      r = int'(a) + int'(b) + int'(c);
      return r[8:0];
   endfunction

   function automatic logic ref_ovf8(input logic [7:0] a, input logic [7:0] b, input logic c);
      int sa;
      int sb;
      int r;
      sa = (a >= 128) ? int'(a) - 256 : int'(a);
      sb = (b >= 128) ? int'(b) - 256 : int'(b);
      r  = sa + sb + int'(c);
      return (r > 127) || (r < -128);
   endfunction

   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
      @(negedge clk);
      bus8.a_in  = a;
      bus8.b_in  = b;
      bus8.cin   = c;
      bus8.start = 1'b1;
      @(posedge clk);
      #1;
      bus8.start = 1'b0;
   endtask

   // Called #1 after the start edge; lat counts edges including the start edge.
   task automatic wait_done8(output int lat, output int busy_cycles);
      lat = 1;
      busy_cycles = bus8.busy ? 1 : 0;
      while (!bus8.done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus8.busy) busy_cycles++;
      end
   endtask

   task automatic finish8(input string name, input logic [8:0] exp_res, input logic exp_ovf);
      int lat;
      int bc;
      wait_done8(lat, bc);
      check({name, "_latency"}, lat, 9);
      check({name, "_busy_cycles"}, bc, 8);
      check({name, "_result"}, {bus8.cout, bus8.sum}, exp_res);
`ifdef SERIAL_ADD_OVF_EN
      check({name, "_ovf"}, bus8.ovf, exp_ovf);
`else
      if (exp_ovf === 1'bx) check({name, "_ovf_model"}, exp_ovf, 1'b0);
`endif
      @(posedge clk);
      #1;
      check({name, "_done_pulse"}, bus8.done, 1'b0);
   endtask

   task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b, input logic c);
      start8(a, b, c);
      finish8(name, ref_add8(a, b, c), ref_ovf8(a, b, c));
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
      int lat;
      int unsigned r;
      @(negedge clk);
      bus4.a_in  = a;
      bus4.b_in  = b;
      bus4.cin   = c;
      bus4.start = 1'b1;
      @(posedge clk);
      #1;
      bus4.start = 1'b0;
      lat = 1;
      while (!bus4.done && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r = int'(a) + int'(b) + int'(c);
      check("w4_latency", lat, 5);
      check("w4_result", {bus4.cout, bus4.sum}, r[4:0]);
      @(posedge clk);
   endtask

   initial begin
      int lat;
      int bc;
      int done_seen;

      vecs[0] = '{a: 8'h05, b: 8'h03, c: 1'b0, s: 8'h08, co: 1'b0, ov: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b1, s: 8'h01, co: 1'b1, ov: 1'b0};
      vecs[2] = '{a: 8'h7F, b: 8'h01, c: 1'b0, s: 8'h80, co: 1'b0, ov: 1'b1};
      vecs[3] = '{a: 8'h00, b: 8'h00, c: 1'b0, s: 8'h00, co: 1'b0, ov: 1'b0};
      vecs[4] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, s: 8'hFF, co: 1'b1, ov: 1'b0};
      vecs[5] = '{a: 8'h80, b: 8'h80, c: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b1};
      vecs[6] = '{a: 8'hA5, b: 8'h5A, c: 1'b1, s: 8'h00, co: 1'b1, ov: 1'b0};
      vecs[7] = '{a: 8'h00, b: 8'h00, c: 1'b1, s: 8'h01, co: 1'b0, ov: 1'b0};

      rst_n = 1'b0;
      bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.cin = 1'b0;
      bus4.start = 1'b0; bus4.a_in = '0; bus4.b_in = '0; bus4.cin = 1'b0;
      #3;
      check("rst_busy", bus8.busy, 1'b0);
      check("rst_done", bus8.done, 1'b0);
      check("rst_sum_cout", {bus8.cout, bus8.sum}, 9'h000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors.
      for (int i = 0; i < 8; i++) begin
         start8(vecs[i].a, vecs[i].b, vecs[i].c);
         finish8($sformatf("vec%0d", i), {vecs[i].co, vecs[i].s}, vecs[i].ov);
      end

      // start held high, operands change during SHIFT; back-to-back restart.
      @(negedge clk);
      bus8.a_in = 8'h10; bus8.b_in = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
      @(posedge clk);
      #1;
      bus8.a_in = 8'hAA; bus8.b_in = 8'h55;
      wait_done8(lat, bc);
      check("hold_latency", lat, 9);
      check("hold_result", {bus8.cout, bus8.sum}, 9'h030);
      @(posedge clk);
      #1;
      check("hold_idle_done", bus8.done, 1'b0);
      check("hold_idle_busy", bus8.busy, 1'b0);
      @(posedge clk);
      #1;
      check("hold_restart_busy", bus8.busy, 1'b1);
      bus8.start = 1'b0;
      finish8("hold2", 9'h0FF, 1'b0);

      // Reset pulsed during the 4th SHIFT cycle: abort with no done pulse.
      start8(8'h33, 8'h44, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", bus8.busy, 1'b0);
      check("midrst_done", bus8.done, 1'b0);
      check("midrst_sum_cout", {bus8.cout, bus8.sum}, 9'h000);
      done_seen = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         #1;
         if (bus8.done) done_seen++;
      end
      check("midrst_no_done", done_seen, 0);
      op8("after_rst", 8'h33, 8'h44, 1'b1);

      // Random operations against the arithmetic reference.
      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         logic       rc;
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom_range(0, 1));
         op8($sformatf("rand%0d", i), ra, rb, rc);
      end

      // Exhaustive WIDTH=4 sweep.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               op4(4'(a), 4'(b), 1'(c));
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
